apb_slave_mem: RTL and testbench
================================

Name: apb_slave_mem

Overview:
APB slave that sits directly downstream of master_bridge and answers one of its select lines (PSEL1 or PSEL2).
- Decodes PADDR into a local register-file memory; performs writes and returns read data.
- Inserts a configurable number of wait states via PREADY.
- Flags out-of-range accesses on PSLVERR.
- Two instances with different MEM_DEPTH / WAIT_CYCLES form the slave side of the APB test system.

Parameters:
ADDR_WIDTH, 8, local address bits used from PADDR[ADDR_WIDTH-1:0]; PADDR[8] is the master's slave-select bit and is ignored here.
DATA_WIDTH, 8, width of PWDATA/PRDATA.
MEM_DEPTH, 64, number of words; must be at most 2**ADDR_WIDTH.
WAIT_CYCLES, 2, access-phase cycles with PREADY low before completion; legal range 0..15.

Ports:
PCLK  in  1  clock; all logic on the rising edge.
PRESETn  in  1  asynchronous active-low reset.
PSEL  in  1  slave select from the master.
PENABLE  in  1  access-phase strobe.
PWRITE  in  1  1 = write, 0 = read.
PADDR  in  9  transfer address.
PWDATA  in  DATA_WIDTH  write data.
PRDATA  out  DATA_WIDTH  read data; valid when PREADY=1 and PWRITE=0.
PREADY  out  1  transfer completion.
PSLVERR  out  1  error response; valid only with PREADY=1.

Behaviour:
- Reset (PRESETn=0, asynchronous): FSM goes to IDLE; PREADY=0, PSLVERR=0, PRDATA=0, wait counter=0; all memory words cleared to 0.
- FSM states:
  - IDLE -> SETUP when PSEL=1 and PENABLE=0.
  - SETUP -> WAIT when PSEL&PENABLE and WAIT_CYCLES>0.
  - SETUP -> ACCESS when WAIT_CYCLES=0.
  - WAIT -> ACCESS when the counter expires.
  - ACCESS -> IDLE, or -> SETUP if PSEL=1 and PENABLE=0 (back-to-back transfers).
- Outputs are registered.
  - At the edge leaving SETUP (or the last WAIT edge), PREADY is set to 1 for exactly one cycle.
  - Result: the access phase lasts WAIT_CYCLES+1 cycles; a full transfer lasts 2+WAIT_CYCLES cycles.
- Wait counter: loaded with WAIT_CYCLES on the SETUP edge; decrements once per cycle while PSEL&PENABLE; reaching 1 schedules PREADY.
- Address and PWRITE are captured in SETUP. If PADDR or PWRITE changes during the access phase, the captured values are used.
- Write: memory[addr] <= PWDATA at the edge ending the ACCESS cycle (PSEL&PENABLE&PREADY&PWRITE), only if the address is in range.
- Read: PRDATA is loaded from memory[addr] at the same edge that sets PREADY. PRDATA holds its value until the next completed read; writes leave PRDATA unchanged.
- Out of range means addr >= MEM_DEPTH. Handling depends on APB_SLV_ERR_EN (see Optional Feature).
- PSLVERR is asserted in the same cycle as PREADY and cleared with it.
- Protocol abort: if PSEL drops during SETUP/WAIT/ACCESS, return to IDLE next edge. No write occurs; PREADY and PSLVERR go 0.
- PENABLE=1 seen in IDLE (illegal) is ignored; the block stays in IDLE.
- Reset mid-transfer: immediate return to IDLE; any pending write is discarded.

Optional Feature:
APB_SLV_ERR_EN.
- Defined: an out-of-range access completes with PSLVERR=1. A write does not modify memory; a read returns PRDATA=0.
- Undefined: PSLVERR is tied to 0 and the address wraps modulo MEM_DEPTH (addr % MEM_DEPTH). For power-of-two depth this is a truncation.

Decomposition:
- Package apb_pkg holds:
  - FSM state typedef: IDLE/SETUP/WAIT/ACCESS, 2-bit encoding.
  - APB_ADDR_W=9 and APB_DATA_W=8.
  - SLAVE_SEL_BIT=8.
  - MAX_WAIT=15.
- One sub-module is natural: apb_slave_regfile. It is a synchronous-write, registered-read memory with async clear; the FSM lives in the top.

Test Plan:
- WAIT_CYCLES=2: write 0xA5 to addr 0x05, then read 0x05. Each transfer: PREADY low for 2 access cycles, then high 1 cycle; read gives PRDATA=0xA5, PSLVERR=0.
- WAIT_CYCLES=0, back-to-back writes 0x11@0x00 then 0x22@0x01 with no IDLE between. Each transfer completes in 2 cycles; reads return 0x11 and 0x22.
- APB_SLV_ERR_EN defined, MEM_DEPTH=64: write 0xFF to addr 0x40, then read 0x40. Both transfers give PSLVERR=1 with PREADY; read gives PRDATA=0; word 0x00 is unchanged.
- APB_SLV_ERR_EN undefined: write 0x3C to addr 0x41, read addr 0x01. Result is 0x3C with PSLVERR=0.
- Drop PSEL in the 2nd WAIT cycle of a write of 0x77 to 0x10. FSM returns to IDLE and PREADY never asserts; a read of 0x10 returns the prior value 0x00.
- Assert PRESETn=0 mid-WAIT after writing 0x5A to 0x02. PREADY/PSLVERR/PRDATA go 0 immediately; after reset, a read of 0x02 returns 0x00.

Source files
------------

// File: rtl/apb_pkg.sv
// Shared APB constants and the slave FSM state encoding.
package apb_pkg;

    localparam int APB_ADDR_W    = 9;
    localparam int APB_DATA_W    = 8;
    localparam int SLAVE_SEL_BIT = 8;
    localparam int MAX_WAIT      = 15;

    typedef logic [1:0] apb_state_t;

    localparam apb_state_t S_IDLE   = 2'd0;
    localparam apb_state_t S_SETUP  = 2'd1;
    localparam apb_state_t S_WAIT   = 2'd2;
    localparam apb_state_t S_ACCESS = 2'd3;

endpackage

// File: rtl/apb_slave_regfile.sv
// Word memory with synchronous write, registered read and asynchronous clear.
module apb_slave_regfile #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 64,
    parameter int IDX_W      = 6
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [IDX_W-1:0]      addr,
    input  logic                  we,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  re,
    input  logic                  rclr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[addr] <= wdata;
        end
    end

    // rclr returns zero instead of a word, used for rejected reads.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= rclr ? '0 : mem[addr];
        end
    end

endmodule

// File: rtl/apb_slave_mem.sv
// APB slave with a local register file and WAIT_CYCLES wait states.
// Define APB_SLV_ERR_EN to reject out-of-range accesses with PSLVERR; otherwise addresses wrap.
module apb_slave_mem
    import apb_pkg::*;
#(
    parameter int ADDR_WIDTH  = 8,
    parameter int DATA_WIDTH  = 8,
    parameter int MEM_DEPTH   = 64,
    parameter int WAIT_CYCLES = 2
) (
    input  logic                  PCLK,
    input  logic                  PRESETn,
    input  logic                  PSEL,
    input  logic                  PENABLE,
    input  logic                  PWRITE,
    input  logic [APB_ADDR_W-1:0] PADDR,
    input  logic [DATA_WIDTH-1:0] PWDATA,
    output logic [DATA_WIDTH-1:0] PRDATA,
    output logic                  PREADY,
    output logic                  PSLVERR,
    output logic [1:0]            state_dbg
);

    localparam int              IDX_W   = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam logic [ADDR_WIDTH:0] DEPTH_L = (ADDR_WIDTH + 1)'(MEM_DEPTH);
    localparam logic [3:0]      WAIT_L  = 4'(WAIT_CYCLES);

    // Handshake: a transfer is recognised from PSEL=1/PENABLE=0, then held
    // with PSEL=1/PENABLE=1 until PREADY=1; it completes on that edge.
    apb_state_t            state, state_n;
    logic [3:0]            wait_cnt, cnt_n;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic                  write_q;
    logic                  ready_q, err_q;
    logic                  set_ready;

    logic                  start, active, capture, complete;
    logic [ADDR_WIDTH-1:0] eff_addr;
    logic                  eff_write;
    logic [IDX_W-1:0]      idx;
    logic                  err_resp;
    logic                  mem_we, mem_re;
    logic [APB_ADDR_W-1:ADDR_WIDTH] paddr_unused;

    assign paddr_unused = PADDR[APB_ADDR_W-1:ADDR_WIDTH];

    assign start    = PSEL && !PENABLE;
    assign active   = PSEL && PENABLE;
    assign capture  = start && (state == S_IDLE || state == S_ACCESS);
    assign complete = active && (state == S_ACCESS);

    // With zero wait states the read happens on the capture edge itself,
    // so the live bus values stand in for the not-yet-captured ones.
    assign eff_addr  = capture ? PADDR[ADDR_WIDTH-1:0] : addr_q;
    assign eff_write = capture ? PWRITE : write_q;

`ifdef APB_SLV_ERR_EN
    assign idx      = eff_addr[IDX_W-1:0];
    assign err_resp = ({1'b0, eff_addr} >= DEPTH_L);
`else
    assign idx      = IDX_W'({1'b0, eff_addr} % DEPTH_L);
    assign err_resp = 1'b0;
`endif

    always_comb begin
        state_n   = state;
        cnt_n     = wait_cnt;
        set_ready = 1'b0;
        case (state)
            S_IDLE, S_ACCESS: begin
                state_n = S_IDLE;
                cnt_n   = '0;
                if (capture) begin
                    if (WAIT_L == 4'd0) begin
                        state_n   = S_ACCESS;
                        set_ready = 1'b1;
                    end else begin
                        state_n = S_SETUP;
                        cnt_n   = WAIT_L;
                    end
                end
            end
            S_SETUP, S_WAIT: begin
                if (!PSEL) begin
                    state_n = S_IDLE;
                    cnt_n   = '0;
                end else if (PENABLE) begin
                    cnt_n = wait_cnt - 4'd1;
                    if (wait_cnt == 4'd1) begin
                        state_n   = S_ACCESS;
                        set_ready = 1'b1;
                    end else begin
                        state_n = S_WAIT;
                    end
                end
            end
            default: begin
                state_n = S_IDLE;
                cnt_n   = '0;
            end
        endcase
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state    <= S_IDLE;
            wait_cnt <= '0;
            addr_q   <= '0;
            write_q  <= 1'b0;
            ready_q  <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state    <= state_n;
            wait_cnt <= cnt_n;
            ready_q  <= set_ready;
            err_q    <= set_ready && err_resp;
            if (capture) begin
                addr_q  <= PADDR[ADDR_WIDTH-1:0];
                write_q <= PWRITE;
            end
        end
    end

    assign mem_we = complete && write_q && !err_resp;
    assign mem_re = set_ready && !eff_write;

    apb_slave_regfile #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (MEM_DEPTH),
        .IDX_W      (IDX_W)
    ) u_regfile (
        .clk   (PCLK),
        .rst_n (PRESETn),
        .addr  (idx),
        .we    (mem_we),
        .wdata (PWDATA),
        .re    (mem_re),
        .rclr  (err_resp),
        .rdata (PRDATA)
    );

    assign PREADY    = ready_q;
    assign PSLVERR   = err_q;
    assign state_dbg = state;

endmodule

// File: tb/tb_apb_slave_mem.sv
// Directed bench: dut 0 has 2 wait states / 64 words, dut 1 has 0 wait states / 32 words.
module tb_apb_slave_mem;

    logic       pclk = 1'b0;
    logic       presetn;
    logic       psel    [2];
    logic       penable [2];
    logic       pwrite  [2];
    logic [8:0] paddr   [2];
    logic [7:0] pwdata  [2];
    logic [7:0] prdata  [2];
    logic       pready  [2];
    logic       pslverr [2];
    logic [1:0] state_dbg [2];

    int checks = 0;
    int errors = 0;

    always #5 pclk = ~pclk;

    apb_slave_mem #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .MEM_DEPTH(64), .WAIT_CYCLES(2)) dut0 (
        .PCLK(pclk), .PRESETn(presetn), .PSEL(psel[0]), .PENABLE(penable[0]),
        .PWRITE(pwrite[0]), .PADDR(paddr[0]), .PWDATA(pwdata[0]), .PRDATA(prdata[0]),
        .PREADY(pready[0]), .PSLVERR(pslverr[0]), .state_dbg(state_dbg[0])
    );

    apb_slave_mem #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .MEM_DEPTH(32), .WAIT_CYCLES(0)) dut1 (
        .PCLK(pclk), .PRESETn(presetn), .PSEL(psel[1]), .PENABLE(penable[1]),
        .PWRITE(pwrite[1]), .PADDR(paddr[1]), .PWDATA(pwdata[1]), .PRDATA(prdata[1]),
        .PREADY(pready[1]), .PSLVERR(pslverr[1]), .state_dbg(state_dbg[1])
    );

    // Setup cycle then access phase; returns once PREADY is seen (or 20 cycles pass).
    task automatic apb_start(input int d, input logic wr, input logic [8:0] addr,
                             input logic [7:0] wd, output int waits,
                             output logic [7:0] rd, output logic err, output logic pre_rdy);
        @(posedge pclk); #1;
        psel[d] = 1'b1; penable[d] = 1'b0; pwrite[d] = wr; paddr[d] = addr; pwdata[d] = wd;
        pre_rdy = pready[d];
        @(posedge pclk); #1;
        penable[d] = 1'b1;
        waits = 0;
        while (pready[d] !== 1'b1 && waits < 20) begin
            @(posedge pclk); #1;
            waits++;
        end
        rd  = prdata[d];
        err = pslverr[d];
    endtask

    task automatic apb_idle(input int d);
        @(posedge pclk); #1;
        psel[d] = 1'b0; penable[d] = 1'b0; pwrite[d] = 1'b0;
    endtask

    task automatic test_reset();
        presetn = 1'b0;
        for (int d = 0; d < 2; d++) begin
            psel[d] = 1'b0; penable[d] = 1'b0; pwrite[d] = 1'b0; paddr[d] = '0; pwdata[d] = '0;
        end
        repeat (3) @(posedge pclk);
        #1;
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (pready[d] !== 1'b0) begin errors++; $display("FAIL reset_pready d%0d: got %b expected 0", d, pready[d]); end
            checks++;
            if (pslverr[d] !== 1'b0) begin errors++; $display("FAIL reset_pslverr d%0d: got %b expected 0", d, pslverr[d]); end
            checks++;
            if (prdata[d] !== 8'h00) begin errors++; $display("FAIL reset_prdata d%0d: got %h expected 00", d, prdata[d]); end
            checks++;
            if (state_dbg[d] !== 2'd0) begin errors++; $display("FAIL reset_state d%0d: got %0d expected 0", d, state_dbg[d]); end
        end
        @(negedge pclk);
        presetn = 1'b1;
    endtask

    task automatic test_wait_states();
        int w; logic [7:0] rd; logic e, pr;
        apb_start(0, 1'b1, 9'h005, 8'hA5, w, rd, e, pr);
        checks++;
        if (w !== 2) begin errors++; $display("FAIL ws_write_waits: got %0d expected 2", w); end
        checks++;
        if (e !== 1'b0) begin errors++; $display("FAIL ws_write_err: got %b expected 0", e); end
        apb_idle(0);
        checks++;
        if (pready[0] !== 1'b0) begin errors++; $display("FAIL ws_ready_pulse: got %b expected 0", pready[0]); end
        apb_start(0, 1'b0, 9'h005, 8'h00, w, rd, e, pr);
        checks++;
        if (w !== 2) begin errors++; $display("FAIL ws_read_waits: got %0d expected 2", w); end
        checks++;
        if (rd !== 8'hA5) begin errors++; $display("FAIL ws_read_data: got %h expected a5", rd); end
        checks++;
        if (e !== 1'b0) begin errors++; $display("FAIL ws_read_err: got %b expected 0", e); end
        apb_idle(0);
        // bit 8 is the master's select bit and must not affect decoding
        apb_start(0, 1'b0, 9'h105, 8'h00, w, rd, e, pr);
        checks++;
        if (rd !== 8'hA5) begin errors++; $display("FAIL ws_selbit_read: got %h expected a5", rd); end
        apb_idle(0);
    endtask

    task automatic test_back_to_back();
        int w; logic [7:0] rd; logic e, pr;
        apb_start(1, 1'b1, 9'h000, 8'h11, w, rd, e, pr);
        checks++;
        if (w !== 0) begin errors++; $display("FAIL b2b_w0_waits: got %0d expected 0", w); end
        apb_start(1, 1'b1, 9'h001, 8'h22, w, rd, e, pr);
        checks++;
        if (pr !== 1'b0) begin errors++; $display("FAIL b2b_gap_ready: got %b expected 0", pr); end
        checks++;
        if (w !== 0) begin errors++; $display("FAIL b2b_w1_waits: got %0d expected 0", w); end
        apb_idle(1);
        apb_start(1, 1'b0, 9'h000, 8'h00, w, rd, e, pr);
        checks++;
        if (rd !== 8'h11) begin errors++; $display("FAIL b2b_read0: got %h expected 11", rd); end
        apb_start(1, 1'b0, 9'h001, 8'h00, w, rd, e, pr);
        checks++;
        if (rd !== 8'h22) begin errors++; $display("FAIL b2b_read1: got %h expected 22", rd); end
        apb_start(1, 1'b1, 9'h002, 8'h33, w, rd, e, pr);
        apb_idle(1);
        checks++;
        if (prdata[1] !== 8'h22) begin errors++; $display("FAIL b2b_prdata_hold: got %h expected 22", prdata[1]); end
    endtask

    task automatic test_capture();
        int w; logic [7:0] rd; logic e, pr;
        @(posedge pclk); #1;
        psel[0] = 1'b1; penable[0] = 1'b0; pwrite[0] = 1'b0; paddr[0] = 9'h005;
        @(posedge pclk); #1;
        penable[0] = 1'b1; pwrite[0] = 1'b1; paddr[0] = 9'h006; pwdata[0] = 8'hEE;
        w = 0;
        while (pready[0] !== 1'b1 && w < 20) begin @(posedge pclk); #1; w++; end
        checks++;
        if (prdata[0] !== 8'hA5) begin errors++; $display("FAIL cap_read_data: got %h expected a5", prdata[0]); end
        apb_idle(0);
        apb_start(0, 1'b0, 9'h006, 8'h00, w, rd, e, pr);
        checks++;
        if (rd !== 8'h00) begin errors++; $display("FAIL cap_no_write: got %h expected 00", rd); end
        apb_idle(0);
    endtask

`ifdef APB_SLV_ERR_EN
    task automatic test_range();
        int w; logic [7:0] rd; logic e, pr;
        apb_start(0, 1'b1, 9'h040, 8'hFF, w, rd, e, pr);
        checks++;
        if (e !== 1'b1) begin errors++; $display("FAIL err_write_slverr: got %b expected 1", e); end
        checks++;
        if (w !== 2) begin errors++; $display("FAIL err_write_waits: got %0d expected 2", w); end
        apb_idle(0);
        checks++;
        if (pslverr[0] !== 1'b0) begin errors++; $display("FAIL err_clear: got %b expected 0", pslverr[0]); end
        apb_start(0, 1'b0, 9'h005, 8'h00, w, rd, e, pr);
        apb_idle(0);
        apb_start(0, 1'b0, 9'h040, 8'h00, w, rd, e, pr);
        checks++;
        if (e !== 1'b1) begin errors++; $display("FAIL err_read_slverr: got %b expected 1", e); end
        checks++;
        if (rd !== 8'h00) begin errors++; $display("FAIL err_read_data: got %h expected 00", rd); end
        apb_idle(0);
        apb_start(0, 1'b0, 9'h000, 8'h00, w, rd, e, pr);
        checks++;
        if (rd !== 8'h00 || e !== 1'b0) begin errors++; $display("FAIL err_word0: got %h/%b expected 00/0", rd, e); end
        apb_idle(0);
    endtask
`else
    task automatic test_range();
        int w; logic [7:0] rd; logic e, pr;
        apb_start(0, 1'b1, 9'h041, 8'h3C, w, rd, e, pr);
        checks++;
        if (e !== 1'b0) begin errors++; $display("FAIL wrap_write_slverr: got %b expected 0", e); end
        apb_idle(0);
        apb_start(0, 1'b0, 9'h001, 8'h00, w, rd, e, pr);
        checks++;
        if (rd !== 8'h3C) begin errors++; $display("FAIL wrap_read_data: got %h expected 3c", rd); end
        checks++;
        if (e !== 1'b0) begin errors++; $display("FAIL wrap_read_slverr: got %b expected 0", e); end
        apb_idle(0);
    endtask
`endif

    task automatic test_illegal_enable();
        @(posedge pclk); #1;
        psel[0] = 1'b0; penable[0] = 1'b1;
        repeat (2) @(posedge pclk);
        #1;
        psel[0] = 1'b1;
        repeat (3) @(posedge pclk);
        #1;
        checks++;
        if (state_dbg[0] !== 2'd0) begin errors++; $display("FAIL illegal_en_state: got %0d expected 0", state_dbg[0]); end
        checks++;
        if (pready[0] !== 1'b0) begin errors++; $display("FAIL illegal_en_ready: got %b expected 0", pready[0]); end
        psel[0] = 1'b0; penable[0] = 1'b0;
    endtask

    task automatic test_abort();
        int w; logic [7:0] rd; logic e, pr; logic seen;
        @(posedge pclk); #1;
        psel[0] = 1'b1; penable[0] = 1'b0; pwrite[0] = 1'b1; paddr[0] = 9'h010; pwdata[0] = 8'h77;
        @(posedge pclk); #1;
        penable[0] = 1'b1;
        @(posedge pclk); #1;
        checks++;
        if (state_dbg[0] !== 2'd2) begin errors++; $display("FAIL abort_in_wait: got %0d expected 2", state_dbg[0]); end
        psel[0] = 1'b0; penable[0] = 1'b0;
        seen = 1'b0;
        repeat (4) begin
            @(posedge pclk); #1;
            if (pready[0] !== 1'b0) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) begin errors++; $display("FAIL abort_ready: got 1 expected 0"); end
        checks++;
        if (state_dbg[0] !== 2'd0) begin errors++; $display("FAIL abort_state: got %0d expected 0", state_dbg[0]); end
        apb_start(0, 1'b0, 9'h010, 8'h00, w, rd, e, pr);
        checks++;
        if (rd !== 8'h00) begin errors++; $display("FAIL abort_no_write: got %h expected 00", rd); end
        apb_idle(0);
    endtask

    task automatic test_reset_mid();
        int w; logic [7:0] rd; logic e, pr;
        apb_start(0, 1'b1, 9'h002, 8'h5A, w, rd, e, pr);
        apb_idle(0);
        apb_start(0, 1'b0, 9'h002, 8'h00, w, rd, e, pr);
        checks++;
        if (rd !== 8'h5A) begin errors++; $display("FAIL rst_pre_read: got %h expected 5a", rd); end
        apb_idle(0);
        @(posedge pclk); #1;
        psel[0] = 1'b1; penable[0] = 1'b0; pwrite[0] = 1'b1; paddr[0] = 9'h002; pwdata[0] = 8'h99;
        @(posedge pclk); #1;
        penable[0] = 1'b1;
        @(posedge pclk); #2;
        presetn = 1'b0;
        #1;
        checks++;
        if (pready[0] !== 1'b0 || pslverr[0] !== 1'b0) begin
            errors++; $display("FAIL rst_mid_flags: got %b/%b expected 0/0", pready[0], pslverr[0]);
        end
        checks++;
        if (prdata[0] !== 8'h00) begin errors++; $display("FAIL rst_mid_prdata: got %h expected 00", prdata[0]); end
        checks++;
        if (state_dbg[0] !== 2'd0) begin errors++; $display("FAIL rst_mid_state: got %0d expected 0", state_dbg[0]); end
        psel[0] = 1'b0; penable[0] = 1'b0; pwrite[0] = 1'b0;
        @(negedge pclk);
        presetn = 1'b1;
        apb_start(0, 1'b0, 9'h002, 8'h00, w, rd, e, pr);
        checks++;
        if (rd !== 8'h00) begin errors++; $display("FAIL rst_post_read: got %h expected 00", rd); end
        apb_idle(0);
    endtask

    initial begin
        test_reset();
        test_wait_states();
        test_back_to_back();
        test_capture();
        test_range();
        test_illegal_enable();
        test_abort();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
